// File: rtl/vx_bf16_align_pkg.sv
// ============================================================================
// Module      : vx_bf16_align_pkg
// Description : Shared bf16 constants and unpacked-operand type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vx_bf16_align_pkg;

    localparam int BF16_BIAS   = 127;
    localparam int BF16_EXP_W  = 8;
    localparam int BF16_FRAC_W = 7;
    localparam int MAN_W       = 32;
    localparam int HIDDEN_POS  = 30;

    typedef struct packed {
        logic             sign;
        logic [15:0]      exp;
        logic [MAN_W-1:0] man;
        logic             is_nan;
        logic             is_inf;
    } bf16_unpacked_t;

endpackage

`default_nettype wire

// File: rtl/vx_bf16_align_unpack.sv
// ============================================================================
// Module      : vx_bf16_align_unpack
// Description : Combinational bf16 -> unpacked sign/exponent/mantissa/flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vx_bf16_align_unpack
    import vx_bf16_align_pkg::*;
(
    input  logic [15:0]    x,
    output bf16_unpacked_t u
);

    logic [BF16_EXP_W-1:0]  w_exp;
    logic [BF16_FRAC_W-1:0] w_frac;
    logic                   w_hidden;
    logic                   w_exp_max;

    assign w_exp     = x[BF16_FRAC_W +: BF16_EXP_W];
    assign w_frac    = x[BF16_FRAC_W-1:0];
    assign w_hidden  = |w_exp;
    assign w_exp_max = &w_exp;

    always_comb begin
        u      = '0;
        u.sign = x[15];
        // Subnormals share the minimum normal exponent, 1 - bias.
        u.exp  = w_hidden ? (16'(w_exp) - 16'(BF16_BIAS)) : (16'd1 - 16'(BF16_BIAS));
        u.man[HIDDEN_POS]                    = w_hidden;
        u.man[HIDDEN_POS-1 -: BF16_FRAC_W]   = w_frac;
        u.is_nan = w_exp_max & (|w_frac);
        u.is_inf = w_exp_max & ~(|w_frac);
    end

endmodule

`default_nettype wire

// File: rtl/vx_bf16_align.sv
// ============================================================================
// Module      : vx_bf16_align
// Description : Two-stage bf16 pre-adder aligner with sticky right shift.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vx_bf16_align
    import vx_bf16_align_pkg::*;
#(
    parameter int TAGW = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    output logic             ready_in,
    input  logic [15:0]      a,
    input  logic [15:0]      b,
    input  logic [TAGW-1:0]  tag_in,
    output logic             valid_out,
    input  logic             ready_out,
    output logic [15:0]      exp_out,
    output logic [MAN_W-1:0] man_big,
    output logic [MAN_W-1:0] man_small,
    output logic             sign_big,
    output logic             sign_small,
    output logic             swap,
    output logic             is_nan,
    output logic             is_inf,
    output logic [TAGW-1:0]  tag_out
);

    bf16_unpacked_t w_ua;
    bf16_unpacked_t w_ub;
    bf16_unpacked_t w_big;
    bf16_unpacked_t w_small;
    logic           w_swap;
    logic [15:0]    w_diff;
    logic [5:0]     w_d_sat;
    logic           w_nan;
    logic           w_inf;
    logic           w_en;

    vx_bf16_align_unpack u_unpack_a (.x(a), .u(w_ua));
    vx_bf16_align_unpack u_unpack_b (.x(b), .u(w_ub));

    assign w_swap  = $signed(w_ub.exp) > $signed(w_ua.exp);
    assign w_big   = w_swap ? w_ub : w_ua;
    assign w_small = w_swap ? w_ua : w_ub;
    assign w_diff  = w_big.exp - w_small.exp;
    // Anything at or past 31 collapses entirely into the sticky bit.
    assign w_d_sat = (w_diff > 16'd31) ? 6'd31 : w_diff[5:0];
    assign w_nan   = w_ua.is_nan | w_ub.is_nan;
    assign w_inf   = ~w_nan & (w_ua.is_inf | w_ub.is_inf);

    assign w_en     = ~valid_out | ready_out;
    assign ready_in = w_en;

    // Stage 1 registers
    logic             r_v1;
    logic [15:0]      r_exp;
    logic [MAN_W-1:0] r_man_b;
    logic [MAN_W-1:0] r_man_s;
    logic             r_sign_b;
    logic             r_sign_s;
    logic             r_swap;
    logic [5:0]       r_d;
    logic             r_nan;
    logic             r_inf;
    logic [TAGW-1:0]  r_tag;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_v1     <= 1'b0;
            r_exp    <= '0;
            r_man_b  <= '0;
            r_man_s  <= '0;
            r_sign_b <= 1'b0;
            r_sign_s <= 1'b0;
            r_swap   <= 1'b0;
            r_d      <= '0;
            r_nan    <= 1'b0;
            r_inf    <= 1'b0;
            r_tag    <= '0;
        end else if (w_en) begin
            r_v1     <= valid_in;
            r_exp    <= w_big.exp;
            r_man_b  <= w_big.man;
            r_man_s  <= w_small.man;
            r_sign_b <= w_big.sign;
            r_sign_s <= w_small.sign;
            r_swap   <= w_swap;
            r_d      <= w_d_sat;
            r_nan    <= w_nan;
            r_inf    <= w_inf;
            r_tag    <= tag_in;
        end
    end

    logic [MAN_W-1:0] w_mask;
    logic             w_sticky;
    logic [MAN_W-1:0] w_man_sh;

    always_comb begin
        w_mask   = (32'd1 << r_d) - 32'd1;
        w_sticky = |(r_man_s & w_mask);
        if (r_d >= 6'd31) begin
            w_man_sh = {31'b0, |r_man_s};
        end else begin
            w_man_sh = (r_man_s >> r_d) | {31'b0, w_sticky};
        end
    end

    // Stage 2 registers drive the outputs directly
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out  <= 1'b0;
            exp_out    <= '0;
            man_big    <= '0;
            man_small  <= '0;
            sign_big   <= 1'b0;
            sign_small <= 1'b0;
            swap       <= 1'b0;
            is_nan     <= 1'b0;
            is_inf     <= 1'b0;
            tag_out    <= '0;
        end else if (w_en) begin
            valid_out  <= r_v1;
            exp_out    <= r_exp;
            man_big    <= r_man_b;
            man_small  <= w_man_sh;
            sign_big   <= r_sign_b;
            sign_small <= r_sign_s;
            swap       <= r_swap;
            is_nan     <= r_nan;
            is_inf     <= r_inf;
            tag_out    <= r_tag;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vx_bf16_align.sv
// ============================================================================
// Module      : tb_vx_bf16_align
// Description : Self-checking bench for the bf16 pre-adder aligner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vx_bf16_align;

    localparam int TAGW = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            valid_in;
    logic            ready_in;
    logic [15:0]     a;
    logic [15:0]     b;
    logic [TAGW-1:0] tag_in;
    logic            valid_out;
    logic            ready_out;
    logic [15:0]     exp_out;
    logic [31:0]     man_big;
    logic [31:0]     man_small;
    logic            sign_big;
    logic            sign_small;
    logic            swap;
    logic            is_nan;
    logic            is_inf;
    logic [TAGW-1:0] tag_out;

    vx_bf16_align #(.TAGW(TAGW)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
        .a(a), .b(b), .tag_in(tag_in), .valid_out(valid_out), .ready_out(ready_out),
        .exp_out(exp_out), .man_big(man_big), .man_small(man_small),
        .sign_big(sign_big), .sign_small(sign_small), .swap(swap),
        .is_nan(is_nan), .is_inf(is_inf), .tag_out(tag_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0]     e;
        logic [31:0]     mb;
        logic [31:0]     ms;
        logic            sb;
        logic            ss;
        logic            sw;
        logic            nan;
        logic            inf;
        logic [TAGW-1:0] tag;
    } res_t;

    res_t q[$];
    res_t cur;
    res_t prev;
    res_t expv;
    logic prev_stall = 1'b0;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference: real-valued exponents and integer mantissas, sticky via remainder.
    function automatic res_t model(input logic [15:0] x, input logic [15:0] y,
                                   input logic [TAGW-1:0] t);
        res_t   r;
        int     ex, ey, ebig, esm, d;
        longint mx, my, mbig, msm, p;
        logic   nan;
        ex = (x[14:7] == 8'd0) ? -126 : int'(x[14:7]) - 127;
        ey = (y[14:7] == 8'd0) ? -126 : int'(y[14:7]) - 127;
        mx = longint'(((x[14:7] != 8'd0) ? 128 : 0) + int'(x[6:0])) * 8388608;
        my = longint'(((y[14:7] != 8'd0) ? 128 : 0) + int'(y[6:0])) * 8388608;
        r  = '0;
        r.sw = (ey > ex);
        if (r.sw) begin
            ebig = ey; esm = ex; mbig = my; msm = mx; r.sb = y[15]; r.ss = x[15];
        end else begin
            ebig = ex; esm = ey; mbig = mx; msm = my; r.sb = x[15]; r.ss = y[15];
        end
        d = ebig - esm;
        if (d >= 31) begin
            r.ms = (msm != 0) ? 32'd1 : 32'd0;
        end else begin
            p    = longint'(1) << d;
            r.ms = 32'(msm / p);
            if ((msm % p) != 0) r.ms[0] = 1'b1;
        end
        r.mb  = 32'(mbig);
        r.e   = 16'(ebig);
        nan   = (x[14:7] == 8'hFF && x[6:0] != 7'd0) || (y[14:7] == 8'hFF && y[6:0] != 7'd0);
        r.nan = nan;
        r.inf = !nan && ((x[14:7] == 8'hFF) || (y[14:7] == 8'hFF));
        r.tag = t;
        return r;
    endfunction

    // Scoreboard: everything observed at negedge is what the next posedge commits.
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            prev_stall = 1'b0;
        end else begin
            cur = {exp_out, man_big, man_small, sign_big, sign_small, swap, is_nan, is_inf, tag_out};
            if (prev_stall) chk("stall_hold", cur, prev);
            if (valid_out && !ready_out) chk("stall_ready_in", ready_in, 1'b0);
            if (valid_out && ready_out) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_result: got valid_out=1 tag=%0h expected no result", tag_out);
                end else begin
                    expv = q.pop_front();
                    chk("result", cur, expv);
                end
            end
            if (valid_in && ready_in) q.push_back(model(a, b, tag_in));
            prev_stall = valid_out && !ready_out;
            prev       = cur;
        end
    end

    task automatic send(input logic [15:0] xa, input logic [15:0] xb, input logic [TAGW-1:0] t);
        int n = 0;
        a = xa; b = xb; tag_in = t; valid_in = 1'b1;
        @(negedge clk);
        while (!ready_in && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!ready_in) begin
            checks++; errors++;
            $display("FAIL send_timeout: got ready_in=0 expected 1 within 50 cycles");
        end
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    logic [15:0] vec_a [12] = '{16'h3F00, 16'h3F80, 16'h7FC0, 16'hFF80, 16'h0000, 16'h0001,
                                16'h3F80, 16'h3F80, 16'hC2F7, 16'h0080, 16'h7F80, 16'h3F80};
    logic [15:0] vec_b [12] = '{16'h3F80, 16'h2B80, 16'h3F80, 16'h3F80, 16'h0000, 16'h8001,
                                16'h30FF, 16'h3000, 16'h4100, 16'h0001, 16'hFF80, 16'hBF80};

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1);
    end

    initial begin
        res_t m;
        int   n;
        reset = 1'b1; valid_in = 1'b0; ready_out = 1'b1;
        a = '0; b = '0; tag_in = '0;

        // Model pinned against hand-computed values
        m = model(16'h3F00, 16'h3F80, 4'h0);
        chk("pin_half_swap", m.sw, 1'b1);
        chk("pin_half_small", m.ms, 32'h2000_0000);
        chk("pin_half_big", m.mb, 32'h4000_0000);
        m = model(16'h3F80, 16'h2B80, 4'h0);
        chk("pin_sticky_only", m.ms, 32'h0000_0001);
        chk("pin_sticky_exp", m.e, 16'h0000);
        m = model(16'h7FC0, 16'h3F80, 4'h0);
        chk("pin_nan", {m.nan, m.inf}, 2'b10);
        m = model(16'hFF80, 16'h3F80, 4'h0);
        chk("pin_inf", {m.inf, m.nan, m.sb}, 3'b101);
        m = model(16'h0000, 16'h0000, 4'h0);
        chk("pin_zero_exp", m.e, 16'hFF82);
        m = model(16'h3F80, 16'h3100, 4'h0);
        chk("pin_d29", m.ms, 32'h0000_0002);

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset_valid_out", valid_out, 1'b0);
        chk("reset_data", {exp_out, man_big, man_small, tag_out}, '0);
        chk("reset_ready_in", ready_in, 1'b1);

        // Latency with literal expectations
        send(16'h3F80, 16'h3F80, 4'h1);
        chk("lat_v_cycle1", valid_out, 1'b0);
        @(posedge clk); #1;
        chk("lat_v_cycle2", valid_out, 1'b1);
        chk("lat_exp", exp_out, 16'h0000);
        chk("lat_mans", {man_big, man_small}, {32'h4000_0000, 32'h4000_0000});
        chk("lat_swap", swap, 1'b0);
        repeat (2) @(posedge clk); #1;

        // Directed vectors streamed back to back
        for (int i = 0; i < 12; i++) send(vec_a[i], vec_b[i], 4'(i + 2));
        repeat (4) @(posedge clk); #1;

        // Stream of four with a three-cycle downstream stall after the first result
        fork
            begin
                send(16'h4040, 16'h3F80, 4'hA);
                send(16'h3E80, 16'h4120, 4'hB);
                send(16'hC000, 16'h4000, 4'hC);
                send(16'h0005, 16'h4780, 4'hD);
            end
            begin
                n = 0;
                @(negedge clk);
                while (!valid_out && n < 20) begin
                    n++;
                    @(negedge clk);
                end
                if (!valid_out) begin
                    checks++; errors++;
                    $display("FAIL stall_wait: got valid_out=0 expected 1 within 20 cycles");
                end
                @(posedge clk); #1 ready_out = 1'b0;
                repeat (3) @(posedge clk);
                #1 ready_out = 1'b1;
            end
        join
        repeat (4) @(posedge clk); #1;

        // Reset with two operations in flight
        send(16'h3F80, 16'h4000, 4'h5);
        send(16'h4000, 16'h3F80, 4'h6);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        chk("midreset_valid_out", valid_out, 1'b0);
        repeat (3) @(posedge clk); #1;
        chk("midreset_no_stale", valid_out, 1'b0);
        send(16'h3F00, 16'h3F80, 4'h7);
        chk("post_reset_lat1", valid_out, 1'b0);
        @(posedge clk); #1;
        chk("post_reset_lat2", valid_out, 1'b1);
        chk("post_reset_small", man_small, 32'h2000_0000);
        chk("post_reset_swap", swap, 1'b1);

        n = 0;
        while (q.size() != 0 && n < 20) begin
            n++;
            @(posedge clk); #1;
        end
        chk("drain_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vx_bf16_align.md
# VX_bf16_align

Two-operand bf16 pre-adder aligner: unpacks operands A and B, selects the larger-exponent operand, and right-shifts the smaller mantissa by the exponent difference with sticky collapse. It is the front end of the bf16 add datapath. Its outputs are a common signed exponent and two 32-bit mantissas in the same layout the bf16 normalizer consumes after the add. It is a 2-stage valid/ready pipeline.

## Interface
- TAGW, 1: width of opaque tag carried alongside each operation.
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- valid_in  in  1  operand pair valid.
- ready_in  out  1  aligner accepts operand pair this cycle.
- a, b  in  16  bf16 operands (sign[15], exp[14:7], frac[6:0]).
- tag_in  in  TAGW  passthrough tag.
- valid_out  out  1  aligned result valid.
- ready_out  in  1  downstream accepts result.
- exp_out  out  16  signed unbiased common exponent.
- man_big, man_small  out  32  aligned mantissas.
- sign_big, sign_small  out  1  signs of the selected operands.
- swap  out  1  1 = B is the big operand.
- is_nan, is_inf  out  1  either operand NaN, or either operand Inf (no NaN).
- tag_out  out  TAGW  tag of this result.

## Operation
- Unpack: hidden = (exp != 0). Unbiased e = exp − 127 for normals and −126 for exp == 0. Sign-extend e to 16 bits.
- Mantissa layout: hidden at bit 30, frac at [29:23], [22:0] zero, bit 31 zero as add headroom.
- Big selection: swap = (e_b > e_a). On equal exponents, A is big.
- exp_out = e_big. d = e_big − e_small, which is ≥ 0.
- Shift for d ≤ 30: man_small = man_s >> d, with bit 0 OR-ed with the OR of all shifted-out bits (sticky).
- Shift for d ≥ 31: man_small = {31'b0, |man_s}.
- man_big is never shifted.
- Specials: is_nan = either exp == 0xFF with frac != 0. is_inf = !is_nan and either exp == 0xFF with frac == 0. Mantissa and exponent outputs are still computed arithmetically for specials; the consumer overrides them.
- Zero operands: hidden = 0, man = 0, sticky = 0.

## Timing
- Stage 1 registers the unpacked fields, swap, d (saturated to 6 bits, max 31), flags and tag.
- Stage 2 registers the shifted/sticky result.
- Latency is 2 cycles from accept to valid_out when ready_out is held high.
- Throughput is 1 operation per cycle.
- Pipeline enable en = !valid_out || ready_out. Both stages advance only when en is high. ready_in = en.
- Stage valid bits: v1 ← valid_in & ready_in, and v2 ← v1, both loaded when en.
- Stall: while valid_out && !ready_out, every output is held bit-stable and ready_in = 0.
- Bubble: valid_in = 0 with en = 1 inserts a bubble. Data registers may update, but their valid bits clear.
- Reset values: v1 = v2 = 0, valid_out = 0, and all data outputs = 0.
- ready_in is 1 in the cycle after reset deasserts.
- Reset mid-operation discards both in-flight entries; no result is emitted for them.
- valid_in is sampled only when ready_in = 1. Behaviour when a or b changes while valid_in && !ready_in is the producer's responsibility, following standard valid/ready rules.

## Structure
- Shared bf16 package:
  - localparams BF16_BIAS = 127, BF16_EXP_W = 8, BF16_FRAC_W = 7, MAN_W = 32, HIDDEN_POS = 30.
  - Packed struct bf16_unpacked_t {sign, exp[15:0], man[31:0], is_nan, is_inf}.
  - These are shared with the normalizer and the packer.
- One sub-module, VX_bf16_unpack: combinational bf16 → bf16_unpacked_t, instantiated twice in stage 1.
- The sticky right-shifter is inline in stage 2.
- The pipeline registers with enable, and the valid bits, live in the top level.

## Test plan
- a = 0x3F80, b = 0x3F80:
  - 2 cycles later valid_out = 1, exp_out = 0, man_big = man_small = 0x40000000, swap = 0.
- a = 0x3F00 (0.5), b = 0x3F80 (1.0):
  - swap = 1, exp_out = 0, man_big = 0x40000000, man_small = 0x20000000.
- a = 0x3F80, b = 0x2B80 (2^-40), d = 40:
  - man_small = 0x00000001 (sticky only), exp_out = 0.
- a = 0x7FC0, b = 0x3F80: is_nan = 1, is_inf = 0.
- a = 0xFF80, b = 0x3F80: is_inf = 1, is_nan = 0, sign_big = 1.
- Back-to-back stream of 4 pairs with ready_out low for 3 cycles after the first result:
  - valid_out stays high with all outputs stable.
  - ready_in stays low during the stall.
  - All 4 results emerge in order, tags intact.
- reset pulsed while 2 operations are in flight: valid_out = 0 in the next cycle, no stale result appears, and the next accepted pair completes with 2-cycle latency.
